// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM with a one-cycle registered read,
// plus a small MMIO window (cycle counter, LED register, RAM write counter)
// and a sticky bus-error flag for unmapped accesses.
module dmem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_CYCLE = 32'hFFFF_FFF0,
    parameter logic [31:0] MMIO_LED   = 32'hFFFF_FFF4,
    parameter logic [31:0] MMIO_WRCNT = 32'hFFFF_FFF8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] led_out,
    output logic        bus_error
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     cyc_cnt;
    logic [DATA_W-1:0]     wr_cnt;
    logic [DATA_W-1:0]     led_reg;
    logic [DATA_W-1:0]     rd_data_p0;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_hit;
    logic                  cyc_hit;
    logic                  led_hit;
    logic                  wrcnt_hit;
    logic                  unmapped;
    logic                  ram_we;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + DATA_W'(1);
    endfunction

    // Address decode and write qualification; reset cycles never write.
    always_comb begin
        ram_addr  = address_dmem[ADDR_WIDTH-1:0];
        ram_hit   = (address_dmem[31:ADDR_WIDTH] == '0);
        cyc_hit   = (address_dmem == MMIO_CYCLE);
        led_hit   = (address_dmem == MMIO_LED);
        wrcnt_hit = (address_dmem == MMIO_WRCNT);
        unmapped  = !(ram_hit || cyc_hit || led_hit || wrcnt_hit);
        ram_we    = wren && ram_hit && !reset;
    end

    // Stage p0: select read data, write-first for every writable target.
    always_comb begin
        rd_data_p0 = '0;
        if (ram_hit) begin
            rd_data_p0 = wren ? data : mem[ram_addr];
        end else if (cyc_hit) begin
            rd_data_p0 = wren ? data : cyc_cnt;
        end else if (led_hit) begin
            rd_data_p0 = wren ? data : led_reg;
        end else if (wrcnt_hit) begin
            rd_data_p0 = wr_cnt;
        end
    end

    // RAM array: no reset, contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr] <= data;
        end
    end

    // Stage p1: registered read data, MMIO state and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem    <= '0;
            cyc_cnt   <= '0;
            wr_cnt    <= '0;
            led_reg   <= '0;
            bus_error <= 1'b0;
        end else begin
            q_dmem    <= rd_data_p0;
            cyc_cnt   <= (wren && cyc_hit) ? data : cyc_cnt + DATA_W'(1);
            if (wren && led_hit) begin
                led_reg <= data;
            end
            if (ram_we) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
            bus_error <= bus_error | unmapped;
        end
    end

    assign led_out = led_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scenario tasks drive stimulus,
// push the expected q_dmem into a scoreboard queue and pop it after the edge.
module tb_dmem_responder;

    localparam logic [31:0] MMIO_CYCLE = 32'hFFFF_FFF0;
    localparam logic [31:0] MMIO_LED   = 32'hFFFF_FFF4;
    localparam logic [31:0] MMIO_WRCNT = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [31:0] led_out;
    logic        bus_error;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [31:0] want;

    dmem_responder #(
        .ADDR_WIDTH(12),
        .MMIO_CYCLE(MMIO_CYCLE),
        .MMIO_LED  (MMIO_LED),
        .MMIO_WRCNT(MMIO_WRCNT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .q_dmem      (q_dmem),
        .led_out     (led_out),
        .bus_error   (bus_error)
    );

    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs and return 1 time unit after the edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w);
        reset        = r;
        address_dmem = a;
        data         = d;
        wren         = w;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 32'd5, 32'h1111, 1'b1);
        step(1'b1, 32'd5, 32'h1111, 1'b1);
        total++; if (q_dmem !== 32'h0) begin bad++; $display("FAIL reset_q got=%h req=%h", q_dmem, 32'h0); end
        total++; if (led_out !== 32'h0) begin bad++; $display("FAIL reset_led got=%h req=%h", led_out, 32'h0); end
        total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL reset_berr got=%b req=0", bus_error); end
    endtask

    task automatic test_ram_rw();
        exp_q.push_back(32'hDEADBEEF);
        step(1'b0, 32'd5, 32'hDEADBEEF, 1'b1);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL ram_wr_first got=%h req=%h", q_dmem, want); end
        exp_q.push_back(32'hDEADBEEF);
        step(1'b0, 32'd5, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL ram_read got=%h req=%h", q_dmem, want); end
        exp_q.push_back(32'd1);
        step(1'b0, MMIO_WRCNT, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL wrcnt_one got=%h req=%h", q_dmem, want); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'd0, 32'h0, 1'b0);
        exp_q.push_back(32'hDEADBEEF);
        step(1'b0, 32'd5, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL ram_kept_over_reset got=%h req=%h", q_dmem, want); end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        step(1'b0, 32'd7, 32'h1, 1'b1);
        got = q_dmem;
        want = exp_q.pop_front();
        total++; if (got !== want) begin bad++; $display("FAIL b2b_first got=%h req=%h", got, want); end
        step(1'b0, 32'd7, 32'h2, 1'b1);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL b2b_second got=%h req=%h", q_dmem, want); end
        exp_q.push_back(32'd2);
        step(1'b0, MMIO_WRCNT, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL wrcnt_two got=%h req=%h", q_dmem, want); end
    endtask

    task automatic test_cycle_wrap();
        logic [31:0] seq [4];
        seq[0] = 32'hFFFF_FFFE;
        seq[1] = 32'hFFFF_FFFF;
        seq[2] = 32'h0000_0000;
        seq[3] = 32'h0000_0001;
        step(1'b0, MMIO_CYCLE, 32'hFFFF_FFFE, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(seq[i]);
            step(1'b0, MMIO_CYCLE, 32'h0, 1'b0);
            want = exp_q.pop_front();
            total++; if (q_dmem !== want) begin bad++; $display("FAIL cycle_read%0d got=%h req=%h", i, q_dmem, want); end
        end
    endtask

    task automatic test_led_wrcnt();
        exp_q.push_back(32'hA5);
        step(1'b0, MMIO_LED, 32'h0000_00A5, 1'b1);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL led_q got=%h req=%h", q_dmem, want); end
        total++; if (led_out !== 32'hA5) begin bad++; $display("FAIL led_out got=%h req=%h", led_out, 32'hA5); end
        step(1'b0, MMIO_WRCNT, 32'h1234, 1'b1);
        exp_q.push_back(32'd2);
        step(1'b0, MMIO_WRCNT, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL wrcnt_ro got=%h req=%h", q_dmem, want); end
        total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL wrcnt_no_berr got=%b req=0", bus_error); end
        total++; if (led_out !== 32'hA5) begin bad++; $display("FAIL led_hold got=%h req=%h", led_out, 32'hA5); end
    endtask

    task automatic test_unmapped();
        step(1'b0, 32'd0, 32'h11, 1'b1);
        exp_q.push_back(32'h0);
        step(1'b0, 32'h0000_2000, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL unmapped_q got=%h req=%h", q_dmem, want); end
        total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL unmapped_berr got=%b req=1", bus_error); end
        step(1'b0, 32'h0000_2000, 32'hFEED, 1'b1);
        exp_q.push_back(32'h11);
        step(1'b0, 32'd0, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL unmapped_wr_dropped got=%h req=%h", q_dmem, want); end
        exp_q.push_back(32'hA5);
        step(1'b0, MMIO_LED, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL led_after_berr got=%h req=%h", q_dmem, want); end
        total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL berr_sticky got=%b req=1", bus_error); end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 32'd3, 32'hAA, 1'b1);
        step(1'b1, 32'd3, 32'h55, 1'b1);
        total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL berr_cleared got=%b req=0", bus_error); end
        total++; if (led_out !== 32'h0) begin bad++; $display("FAIL led_cleared got=%h req=%h", led_out, 32'h0); end
        exp_q.push_back(32'hAA);
        step(1'b0, 32'd3, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL reset_wr_ignored got=%h req=%h", q_dmem, want); end
        exp_q.push_back(32'd0);
        step(1'b0, MMIO_WRCNT, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL wrcnt_cleared got=%h req=%h", q_dmem, want); end
        step(1'b1, MMIO_CYCLE, 32'h0, 1'b0);
        exp_q.push_back(32'd0);
        step(1'b0, MMIO_CYCLE, 32'h0, 1'b0);
        want = exp_q.pop_front();
        total++; if (q_dmem !== want) begin bad++; $display("FAIL cycle_cleared got=%h req=%h", q_dmem, want); end
        total++; if (led_out !== 32'h0) begin bad++; $display("FAIL led_after_reset got=%h req=%h", led_out, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_back_to_back();
        test_cycle_wrap();
        test_led_wrcnt();
        test_unmapped();
        test_reset_midstream();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d req=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
